seq_restoring_divider: RTL and testbench



---
 rtl/mul_div_pkg.sv | 13 +
 rtl/div_step.sv | 23 ++
 rtl/seq_restoring_divider.sv | 140 ++++++++++++++
 tb/tb_seq_restoring_divider.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Shared types and constants for the multiply/divide datapath.
package mul_div_pkg;

    localparam int DIV_W     = 8;
    localparam int DIV_CNT_W = $clog2(DIV_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the {R,Q} pair left by one bit,
// then subtract the divisor when the shifted remainder can absorb it.
module div_step
    import mul_div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W:0]   r,
    input  logic         q_msb,
    input  logic [W-1:0] divisor,
    output logic [W:0]   r_next,
    output logic         q_bit
);

    // Carrying the full R into a W+2 bit compare keeps the step exact
    // even when R arrives with its top bit set.
    logic [W+1:0] shifted;

    assign shifted = {r, q_msb};
    assign q_bit   = (shifted >= {2'b00, divisor});
    assign r_next  = q_bit ? (shifted[W:0] - {1'b0, divisor}) : shifted[W:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential radix-2 restoring divider: 2W-bit dividend / W-bit divisor.
// Define DIV_FAST_OVF_EN to let overflow operations skip the RUN iterations.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one shift/subtract step per cycle, W steps total
// DONE  | result held on the outputs until out_ready
module seq_restoring_divider
    import mul_div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] operand_a,
    input  logic [W-1:0]   operand_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           overflow,
    output logic           div_by_zero
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    div_state_e state_q, state_d;

    logic [W:0]       r_q;
    logic [W-1:0]     q_q;
    logic [W-1:0]     dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             dz_q;

    logic             ovf_in;
    logic             dz_in;
    logic [W:0]       r_next;
    logic             q_bit;

    assign ovf_in = (operand_a[2*W-1:W] >= operand_b);
    assign dz_in  = (operand_b == '0);

    div_step #(.W(W)) u_div_step (
        .r       (r_q),
        .q_msb   (q_q[W-1]),
        .divisor (dvs_q),
        .r_next  (r_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef DIV_FAST_OVF_EN
                    state_d = ovf_in ? DONE : RUN;
`else
                    state_d = RUN;
`endif
                end
            end
            RUN:     if (cnt_q == '0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Result registers load only on the transition into DONE, so they hold
    // their last value through IDLE and RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q         <= '0;
            q_q         <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        r_q   <= {1'b0, operand_a[2*W-1:W]};
                        q_q   <= operand_a[W-1:0];
                        dvs_q <= operand_b;
                        cnt_q <= CNT_W'(W - 1);
                        ovf_q <= ovf_in;
                        dz_q  <= dz_in;
`ifdef DIV_FAST_OVF_EN
                        if (ovf_in) begin
                            quotient    <= '1;
                            remainder   <= '0;
                            overflow    <= 1'b1;
                            div_by_zero <= dz_in;
                        end
`endif
                    end
                end
                RUN: begin
                    r_q   <= r_next;
                    q_q   <= {q_q[W-2:0], q_bit};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        quotient    <= ovf_q ? '1 : {q_q[W-2:0], q_bit};
                        remainder   <= ovf_q ? '0 : r_next[W-1:0];
                        overflow    <= ovf_q;
                        div_by_zero <= dz_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider (W=8); expectations come from
// integer division in the bench, latencies are counted inclusive of the accept edge.
module tb_seq_restoring_divider;

    localparam int W       = 8;
    localparam int RUN_LAT = W + 1;
`ifdef DIV_FAST_OVF_EN
    localparam int OVF_LAT = 1;
`else
    localparam int OVF_LAT = W + 1;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2*W-1:0] operand_a = '0;
    logic [W-1:0]   operand_b = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           overflow;
    logic           div_by_zero;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2*W-1:0] a;
        logic [W-1:0]   b;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic           ovf;
        logic           dz;
        int             lat;
    } exp_t;

    exp_t sb[$];

    seq_restoring_divider #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [2*W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [15:0] qq;
        logic [15:0] rr;
        e.a   = a;
        e.b   = b;
        e.ovf = (a[2*W-1:W] >= b);
        e.dz  = (b == 0);
        if (e.ovf) begin
            e.q   = '1;
            e.r   = '0;
            e.lat = OVF_LAT;
        end else begin
            qq    = a / {8'h00, b};
            rr    = a % {8'h00, b};
            e.q   = qq[W-1:0];
            e.r   = rr[W-1:0];
            e.lat = RUN_LAT;
        end
        return e;
    endfunction

    // Presents operands until accepted; returns #1 after the accept edge.
    task automatic send(input logic [2*W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(negedge clk);
        operand_a = a;
        operand_b = b;
        in_valid  = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb.push_back(model(a, b));
    endtask

    // Must be called right after send; hold = cycles to keep out_ready low.
    task automatic recv(input int hold);
        exp_t        e;
        int          lat = 1;
        logic [W-1:0] q0, r0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            check("result_timeout", {31'd0, out_valid}, 32'd1);
            return;
        end
        e = sb.pop_front();
        check("latency", lat, e.lat);
        check("quotient", {24'd0, quotient}, {24'd0, e.q});
        check("remainder", {24'd0, remainder}, {24'd0, e.r});
        check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
        check("in_ready_done", {31'd0, in_ready}, 32'd0);
        if (!e.ovf) begin
            check("invariant", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
        end
        q0 = quotient;
        r0 = remainder;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            operand_a = 16'h0005;
            operand_b = 8'h03;
            @(posedge clk);
            #1;
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_quotient", {24'd0, quotient}, {24'd0, q0});
            check("hold_remainder", {24'd0, remainder}, {24'd0, r0});
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_quotient", {24'd0, quotient}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        send(16'h2A5C, 8'h9B); recv(0);
        send(16'hFE01, 8'hFF); recv(0);
        send(16'h0100, 8'h01); recv(0);
        send(16'h1234, 8'h00); recv(0);
        send(16'h0000, 8'h2D); recv(0);
        send(16'h2A5C, 8'h9B); recv(5);
        send(16'h00FF, 8'h01); recv(0);

        for (int i = 0; i < 8; i++) begin
            logic [2*W-1:0] a;
            logic [W-1:0]   b;
            a = 16'($urandom_range(0, 16'hFFFF));
            b = 8'($urandom_range(1, 8'hFF));
            send(a, b);
            recv(i % 2);
        end

        // Asynchronous reset during RUN discards the in-flight operation.
        send(16'h2A5C, 8'h9B);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_quotient", {24'd0, quotient}, 32'd0);
        check("arst_remainder", {24'd0, remainder}, 32'd0);
        check("arst_overflow", {31'd0, overflow}, 32'd0);
        check("arst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        send(16'h0064, 8'h07); recv(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
